// File: rtl/key_repeat_filter_if.sv
// Key conditioning signal bundle: one raw button in, debounced level and event pulses out.
// The master side drives the raw button; the slave side is the filter itself.
interface key_repeat_filter_if;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_repeat;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface

// File: rtl/key_repeat_filter.sv
// Push-button conditioner: synchronise, debounce, and emit level, press/release pulses
// and hold-to-repeat pulses from a single shared counter.
module key_repeat_filter #(
  parameter int DEB_CYCLES = 1000000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000,
  parameter int REPEAT_EN  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  key_repeat_filter_if.slave  kif
);

  localparam int MAX_DR  = (DEB_CYCLES > REP_DELAY) ? DEB_CYCLES : REP_DELAY;
  localparam int MAX_CNT = (MAX_DR > REP_PERIOD) ? MAX_DR : REP_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REP_DELAY);
  localparam logic [CNT_W-1:0] PER_C = CNT_W'(REP_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic             REP_ON   = (REPEAT_EN != 0);
  localparam logic             IDLE_RAW = (ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    ST_RELEASED,
    ST_PRESS_DEB,
    ST_HOLD_WAIT,
    ST_REPEAT,
    ST_RELEASE_DEB
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             key_sync;

  // Two-flop synchroniser, then normalise so 1 always means pressed.
  always_comb begin
    sync1_d  = kif.key_in;
    sync2_d  = sync1_q;
    key_sync = sync2_q ^ IDLE_RAW;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        if (key_sync) begin
          state_d = ST_PRESS_DEB;
          cnt_d   = ONE_C;
        end
      end

      ST_PRESS_DEB: begin
        if (!key_sync) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_C) begin
          state_d  = ST_HOLD_WAIT;
          cnt_d    = ONE_C;
          level_d  = 1'b1;
          press_d  = 1'b1;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end

      ST_HOLD_WAIT: begin
        if (!key_sync) begin
          state_d = ST_RELEASE_DEB;
          cnt_d   = ONE_C;
        end else if (REP_ON) begin
          if (cnt_q == DLY_C) begin
            state_d  = ST_REPEAT;
            cnt_d    = ONE_C;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
      end

      ST_REPEAT: begin
        if (!key_sync) begin
          state_d = ST_RELEASE_DEB;
          cnt_d   = ONE_C;
        end else if (cnt_q == PER_C) begin
          cnt_d    = ONE_C;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end

      ST_RELEASE_DEB: begin
        // A bounce back to pressed resumes holding without a new press event.
        if (key_sync) begin
          state_d = ST_HOLD_WAIT;
          cnt_d   = ONE_C;
        end else if (cnt_q == DEB_C) begin
          state_d   = ST_RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end

      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RELEASED;
      cnt_q     <= '0;
      sync1_q   <= IDLE_RAW;
      sync2_q   <= IDLE_RAW;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign kif.key_level   = level_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_repeat_filter.sv
// Directed bench for key_repeat_filter: per-cycle vector tables for the timing scenarios
// plus hand-written latency and reset-state sequences.
module tb_key_repeat_filter;

  logic clk;
  logic reset;

  key_repeat_filter_if kif_a ();
  key_repeat_filter_if kif_b ();
  key_repeat_filter_if kif_c ();

  key_repeat_filter #(
    .DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(3), .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) u_a (.clk(clk), .reset(reset), .kif(kif_a));

  key_repeat_filter #(
    .DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(3), .REPEAT_EN(0), .ACTIVE_LOW(1)
  ) u_b (.clk(clk), .reset(reset), .kif(kif_b));

  key_repeat_filter #(
    .DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(3), .REPEAT_EN(1), .ACTIVE_LOW(0)
  ) u_c (.clk(clk), .reset(reset), .kif(kif_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp bits: {level, press, release, repeat}
  typedef struct packed {
    logic       pressed;
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [0:63];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_key(input int sel, input logic pressed);
    kif_a.key_in = (sel == 0 && pressed) ? 1'b0 : 1'b1;
    kif_b.key_in = (sel == 1 && pressed) ? 1'b0 : 1'b1;
    kif_c.key_in = (sel == 2 && pressed) ? 1'b1 : 1'b0;
  endtask

  function automatic logic [3:0] outs(input int sel);
    case (sel)
      0:       return {kif_a.key_level, kif_a.key_press, kif_a.key_release, kif_a.key_repeat};
      1:       return {kif_b.key_level, kif_b.key_press, kif_b.key_release, kif_b.key_repeat};
      default: return {kif_c.key_level, kif_c.key_press, kif_c.key_release, kif_c.key_repeat};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_key(-1, 1'b0);
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
  endtask

  task automatic tbl_clear();
    for (int i = 0; i < 64; i++) tbl[i] = '0;
  endtask

  task automatic tbl_key(input int a, input int b);
    for (int i = a; i <= b; i++) tbl[i].pressed = 1'b1;
  endtask

  task automatic tbl_lvl(input int a, input int b);
    for (int i = a; i <= b; i++) tbl[i].exp[3] = 1'b1;
  endtask

  task automatic tbl_pulse(input int c, input int bitn);
    tbl[c].exp[bitn] = 1'b1;
  endtask

  // Inputs of row k are sampled at edge k; outputs are checked just after edge k.
  task automatic run_table(input string sname, input int sel, input int last);
    do_reset();
    for (int k = 0; k <= last; k++) begin
      drive_key(sel, tbl[k].pressed);
      reset = tbl[k].rst;
      step();
      check($sformatf("%s cyc %0d lvl/prs/rel/rep", sname, k), 32'(outs(sel)), 32'(tbl[k].exp));
    end
    reset = 1'b0;
  endtask

  task automatic fill_clean_hold();
    tbl_clear();
    tbl_key(0, 29);
    tbl_lvl(6, 35);
    tbl_pulse(6, 2);
    tbl_pulse(6, 0);
    tbl_pulse(16, 0);
    for (int c = 19; c <= 31; c += 3) tbl_pulse(c, 0);
    tbl_pulse(36, 1);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    drive_key(-1, 1'b0);
    repeat (2) step();

    check("reset_state a", 32'(outs(0)), 32'h0);
    check("reset_state b", 32'(outs(1)), 32'h0);
    check("reset_state c", 32'(outs(2)), 32'h0);

    // Clean hold with auto-repeat
    fill_clean_hold();
    run_table("s1_clean", 0, 40);

    // Bounces shorter than the debounce window
    tbl_clear();
    for (int k = 0; k < 30; k++) tbl[k].pressed = ((k % 6) < 3);
    run_table("s2_bounce", 0, 35);

    // Release glitch while holding
    tbl_clear();
    tbl_key(0, 40);
    tbl[12].pressed = 1'b0;
    tbl[13].pressed = 1'b0;
    tbl_lvl(6, 40);
    tbl_pulse(6, 2);
    tbl_pulse(6, 0);
    for (int c = 26; c <= 38; c += 3) tbl_pulse(c, 0);
    run_table("s3_glitch", 0, 40);

    // Auto-repeat disabled
    tbl_clear();
    tbl_key(0, 39);
    tbl_lvl(6, 45);
    tbl_pulse(6, 2);
    tbl_pulse(6, 0);
    tbl_pulse(46, 1);
    run_table("s4_norep", 1, 50);

    // One-cycle reset mid-hold; key stays held
    tbl_clear();
    tbl_key(0, 50);
    tbl[21].rst = 1'b1;
    tbl_lvl(6, 20);
    tbl_lvl(28, 50);
    tbl_pulse(6, 2);
    tbl_pulse(6, 0);
    tbl_pulse(16, 0);
    tbl_pulse(19, 0);
    tbl_pulse(28, 2);
    tbl_pulse(28, 0);
    for (int c = 38; c <= 50; c += 3) tbl_pulse(c, 0);
    run_table("s5_reset", 0, 50);

    // Active-high polarity, same timing as the clean hold
    fill_clean_hold();
    run_table("s6_acthigh", 2, 40);

    // Hand sequence: press latency, coincident repeat, single-cycle pulse
    do_reset();
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      drive_key(0, 1'b1);
      step();
      if (kif_a.key_press) begin
        lat = i;
        break;
      end
    end
    check("hand press_latency", 32'(lat), 32'd6);
    check("hand press_with_repeat", 32'(kif_a.key_repeat), 32'd1);
    check("hand press_with_level", 32'(kif_a.key_level), 32'd1);
    step();
    check("hand press_one_cycle", 32'({kif_a.key_press, kif_a.key_repeat}), 32'd0);

    // Hand sequence: release latency and level drop in the same cycle
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      drive_key(0, 1'b0);
      step();
      if (kif_a.key_release) begin
        lat = i;
        break;
      end
    end
    check("hand release_latency", 32'(lat), 32'd6);
    check("hand release_level", 32'(kif_a.key_level), 32'd0);
    step();
    check("hand release_one_cycle", 32'(kif_a.key_release), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
